// File: rtl/load_store_unit.sv
// Load/store unit: turns one ALU-addressed load/store request into a word-aligned
// data-memory access over a req/ack handshake and returns extended load data.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            state_dbg
);

  // Handshake: a request is taken on a clk edge where req_valid && req_ready;
  // the memory access completes on an edge where mem_req && mem_ack.
  typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, RESP = 2'd2} state_t;

  state_t state, state_next;

  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [1:0]            lane_q;
  logic                  fault_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            wstrb_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  misaligned;
  logic [3:0]            store_strb;
  logic [DATA_WIDTH-1:0] store_data;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  accept;

  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    misaligned = 1'b0;
    store_strb = 4'b1111;
    store_data = req_wdata;
    case (req_size)
      2'd0: begin
        store_strb = 4'b0001 << req_addr[1:0];
        store_data = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        misaligned = req_addr[0];
        store_strb = 4'b0011 << req_addr[1:0];
        store_data = {2{req_wdata[15:0]}};
      end
      2'd2: misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Extraction uses the lane and size captured at accept, not the live request.
  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    load_data = {{(DATA_WIDTH-8){~uns_q & shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = {{(DATA_WIDTH-16){~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = misaligned ? RESP : MEM;
      MEM:     if (mem_ack) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    mem_req    = (state == MEM);
    resp_valid = (state == RESP);
    mem_we     = (state == MEM) && we_q;
    resp_fault = (state == RESP) && fault_q;
    resp_rdata = (state == RESP) ? rdata_q : '0;
    mem_addr   = addr_q;
    mem_wstrb  = wstrb_q;
    mem_wdata  = wdata_q;
    state_dbg  = state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      lane_q  <= 2'd0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        lane_q  <= req_addr[1:0];
        fault_q <= misaligned;
        addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        wstrb_q <= (req_we && !misaligned) ? store_strb : 4'b0000;
        wdata_q <= req_we ? store_data : '0;
        rdata_q <= '0;
      end
      if ((state == MEM) && mem_ack) rdata_q <= we_q ? '0 : load_data;
    end
  end

endmodule
